ff_cla4: RTL and testbench
==========================

# ff_cla4

Registered 4-bit carry look-ahead adder with no carry-in. Operands are captured in an input register stage, and the sum and per-bit carry vector are captured in an output register stage. It is a pipelined arithmetic leaf block that gives timing-clean CLA results in a synchronous datapath.

## Interface
Parameters:
- WIDTH, default 4, operand, sum and carry-vector width. Only 4 is required to be verified.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high; sampled on the rising clk edge.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- sum  output  WIDTH  registered (a+b) mod 2^WIDTH.
- C_out  output  WIDTH  registered carry vector. C_out[i] is the carry out of bit i. C_out[WIDTH-1] is the final carry-out.

## Operation
- Input stage: on each rising clk edge, Q_a <= a and Q_b <= b.
- CLA core operates combinationally on Q_a and Q_b:
  - g[i] = Q_a[i] & Q_b[i]
  - p[i] = Q_a[i] ^ Q_b[i]
  - c_in[0] = 0
  - c[i] = g[i] | (p[i] & c_in[i])
  - c_in[i+1] = c[i]
  - Each carry is expanded in flattened look-ahead (sum-of-products) form, not rippled.
  - s[i] = p[i] ^ c_in[i]
- Output stage: on each rising clk edge, sum <= s and C_out <= c.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow is indicated only by C_out[WIDTH-1]. There is no saturation.
- No handshake or enable: every cycle accepts a new operand pair, giving a throughput of one result per cycle.

## Timing
- Latency is 2 rising edges from operand sampling to valid outputs:
  - Operands present at edge N appear in Q_a/Q_b after edge N.
  - The corresponding sum/C_out update at edge N+1.
- Operands are sampled on the rising edge. Changes coincident with an edge are treated as arriving for the following edge; the bench drives inputs away from edges.
- Reset (rst=1 at a rising edge):
  - Q_a, Q_b, sum and C_out all become 0 on that edge.
  - Reset has priority over data capture.
- Reset mid-stream: an in-flight result is discarded. After rst deasserts, the first valid result appears 2 edges after the first sampled operand pair.
- While rst is held, outputs remain 0 regardless of a and b.
- Outputs are glitch-free, since they are driven directly from flops.

## Structure
- Shared package ff_cla_pkg holds the WIDTH default constant (4).
- The natural sub-module is cla_core: purely combinational; inputs x and y; outputs s and c (the WIDTH-bit carry vector). It contains the generate/propagate and look-ahead carry equations.
- Top ff_cla4 instantiates the two register stages (input and output) around one cla_core.

## Test plan
- Reset: hold rst=1 for 2 edges with a=9, b=9 -> sum=0, C_out=0000. Release rst with a=0, b=0 -> outputs stay 0.
- Basic add: a=3, b=2 -> 2 edges later sum=5, C_out=0010. Then a=7, b=2 -> sum=9, C_out=0110.
- No-carry cases: a=2, b=13 -> sum=15, C_out=0000. a=4, b=8 -> sum=12, C_out=0000. a=2, b=2 -> sum=4, C_out=0010.
- Full carry chain: a=3, b=13 -> sum=0, C_out=1111 (final carry 1). Also a=15, b=1 -> sum=0, C_out=1111.
- Pipeline: change operands every cycle through the sequence above -> each result is correct and appears exactly 2 edges after its operands, with no skipped or duplicated results. Assert rst for one edge mid-sequence -> the next output is 0, and the pipeline refills correctly afterwards.
- Exhaustive: all 256 (a,b) pairs against a reference model -> {C_out[3], sum} == a+b, and each C_out[i] equals the carry out of bit i.

Source files
------------

// File: rtl/ff_cla_pkg.sv
// Shared constants for the registered carry look-ahead adder family.
package ff_cla_pkg;

  localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/cla_core.sv
// Combinational carry look-ahead adder core with no carry-in.
// Each carry is built as a flattened sum of products over generate/propagate terms.
module cla_core
  import ff_cla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c_in;

  assign g = x & y;
  assign p = x ^ y;

  // c[i] = OR over j<=i of g[j] & p[j+1] & ... & p[i]
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
      logic [gi:0] terms;
      for (genvar gj = 0; gj <= gi; gj++) begin : g_term
        if (gj == gi) begin : g_self
          assign terms[gj] = g[gj];
        end else begin : g_span
          assign terms[gj] = g[gj] & (&p[gi:gj+1]);
        end
      end
      assign c[gi] = |terms;
    end
  endgenerate

  assign c_in = {c[WIDTH-2:0], 1'b0};
  assign s    = p ^ c_in;

endmodule

// File: rtl/ff_cla4.sv
// Two-stage registered CLA adder: operand register, combinational CLA core,
// then a result register for sum and the per-bit carry vector.
module ff_cla4
  import ff_cla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] C_out
);

  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_b;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] c_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= a;
      q_b <= b;
    end
  end

  cla_core #(.WIDTH(WIDTH)) u_core (
    .x (q_a),
    .y (q_b),
    .s (s_next),
    .c (c_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      C_out <= '0;
    end else begin
      sum   <= s_next;
      C_out <= c_next;
    end
  end

endmodule

// File: tb/tb_ff_cla4.sv
// Self-checking bench for ff_cla4: arithmetic reference model with a two-edge
// latency tracker, directed literal cases, exhaustive sweep and random stimulus.
module tb_ff_cla4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = 4'd9;
  logic [W-1:0] b = 4'd9;
  logic [W-1:0] sum;
  logic [W-1:0] C_out;

  int errors = 0;
  int checks = 0;
  logic run_cmp = 1'b1;

  always #5 clk = ~clk;

  ff_cla4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .C_out (C_out)
  );

  function automatic logic [W-1:0] ref_sum(int x, int y);
    logic [W-1:0] r;
    r = W'((x + y) % (1 << W));
    return r;
  endfunction

  // Carry out of bit i is whether the low i+1 bits of the operands overflow.
  function automatic logic [W-1:0] ref_carry(int x, int y);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int m;
      m = 1 << (i + 1);
      r[i] = ((x % m) + (y % m)) >= m;
    end
    return r;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the result visible after edge N is the sum of the operands sampled
  // at edge N-1, or zero if reset was sampled at edge N or N-1.
  logic         prev_rst = 1'b1;
  logic [W-1:0] prev_a = '0;
  logic [W-1:0] prev_b = '0;
  logic [W-1:0] exp_sum = '0;
  logic [W-1:0] exp_c = '0;

  always @(posedge clk) begin
    if (rst || prev_rst) begin
      exp_sum <= '0;
      exp_c   <= '0;
    end else begin
      exp_sum <= ref_sum(int'(prev_a), int'(prev_b));
      exp_c   <= ref_carry(int'(prev_a), int'(prev_b));
    end
    prev_rst <= rst;
    prev_a   <= a;
    prev_b   <= b;
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("model_sum", sum, exp_sum);
      check("model_carry", C_out, exp_c);
    end
  end

  task automatic drive(logic r, int x, int y);
    @(posedge clk);
    #2;
    rst = r;
    a   = W'(x);
    b   = W'(y);
  endtask

  int ta[7] = '{3, 7, 2, 4, 2, 3, 15};
  int tb[7] = '{2, 2, 13, 8, 2, 13, 1};
  int ts[7] = '{5, 9, 15, 12, 4, 0, 0};
  int tc[7] = '{2, 6, 0, 0, 2, 15, 15};

  initial begin
    // Pin the reference model against hand-computed values.
    check("pin_sum_3_13", ref_sum(3, 13), 4'd0);
    check("pin_carry_3_13", ref_carry(3, 13), 4'b1111);
    check("pin_carry_7_2", ref_carry(7, 2), 4'b0110);
    check("pin_carry_2_13", ref_carry(2, 13), 4'b0000);
    check("pin_sum_15_1", ref_sum(15, 1), 4'd0);

    // Reset held for two edges with nonzero operands.
    @(posedge clk);
    @(posedge clk);
    #2;
    check("reset_sum", sum, 4'd0);
    check("reset_carry", C_out, 4'b0000);
    rst = 1'b0;
    a   = '0;
    b   = '0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    check("release_sum", sum, 4'd0);
    check("release_carry", C_out, 4'b0000);

    // Back-to-back directed sequence; op k's result is visible when op k+2 is driven.
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #2;
      if (k >= 2) begin
        check($sformatf("dir_sum_%0d", k - 2), sum, W'(ts[k-2]));
        check($sformatf("dir_carry_%0d", k - 2), C_out, W'(tc[k-2]));
      end
      rst = 1'b0;
      a   = (k < 7) ? W'(ta[k]) : '0;
      b   = (k < 7) ? W'(tb[k]) : '0;
    end

    // One-edge reset in the middle of a stream, then refill.
    drive(0, 3, 2);
    drive(0, 7, 2);
    drive(1, 9, 9);
    drive(0, 4, 8);
    check("midrst_sum", sum, 4'd0);
    check("midrst_carry", C_out, 4'b0000);
    drive(0, 2, 2);
    check("refill0_sum", sum, 4'd0);
    drive(0, 3, 13);
    check("refill1_sum", sum, 4'd12);
    check("refill1_carry", C_out, 4'b0000);
    drive(0, 0, 0);
    check("refill2_sum", sum, 4'd4);
    check("refill2_carry", C_out, 4'b0010);
    drive(0, 0, 0);
    check("refill3_sum", sum, 4'd0);
    check("refill3_carry", C_out, 4'b1111);

    // Exhaustive sweep, one new pair per cycle.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        drive(0, x, y);
      end
    end

    // Random operands with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 19) == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
